// File: rtl/spi_frame_gen.sv
// spi_frame_gen: SPI ADC frame timing generator with free-run period counter and a one-deep start queue
module spi_frame_gen #(
  parameter int CLK_DIV      = 4,
  parameter int FRAME_BITS   = 16,
  parameter int FRAME_PERIOD = 208
) (
  input  logic MCLK,
  input  logic RST_N,
  input  logic EN,
  input  logic START,
  output logic CS_N,
  output logic SCLK,
  output logic BUSY,
  output logic FRAME_DONE
);
  localparam int PW = $clog2(FRAME_PERIOD + 1);
  localparam logic [7:0] DMAX = 8'(CLK_DIV - 1);
  localparam logic [6:0] BMAX = 7'(FRAME_BITS);
  localparam logic [PW-1:0] PMAX = PW'(FRAME_PERIOD - 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, QUIET} state_t;
  state_t r_state, w_state;
  logic [7:0] r_div, w_div;
  logic [6:0] r_bit, w_bit;
  logic [PW-1:0] r_pcnt;
  logic r_pend, r_pend_tick, w_tick, w_req, w_pend, w_start, w_sclk, w_busy;
  assign w_tick = EN && r_pcnt == '0;
  assign w_req = START || w_tick;
  // a queued tick is withdrawn once free-run is switched off; a queued START survives
  assign w_pend = r_pend && !(r_pend_tick && !EN);
  assign w_start = w_req || w_pend;
  assign w_busy = r_state != IDLE;
  always_comb begin
    w_state = r_state;
    w_div = r_div - 8'd1;
    w_bit = r_bit;
    w_sclk = SCLK;
    case (r_state)
      IDLE: begin
        w_div = DMAX;
        w_bit = '0;
        w_state = w_start ? SETUP : IDLE;
      end
      SETUP: if (r_div == '0) begin
        w_state = SHIFT;
        w_div = DMAX;
        w_sclk = 1'b0;
      end
      SHIFT: if (r_div == '0) begin
        w_div = DMAX;
        if (!SCLK) begin
          w_sclk = 1'b1;
          w_bit = r_bit + 7'd1;
        end else if (r_bit == BMAX) w_state = HOLD;
        else w_sclk = 1'b0;
      end
      HOLD: if (r_div == '0) begin
        w_state = QUIET;
        w_div = DMAX;
      end
      QUIET: if (r_div == '0) w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge MCLK) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_div <= '0;
      r_bit <= '0;
      r_pcnt <= '0;
      r_pend <= 1'b0;
      r_pend_tick <= 1'b0;
      CS_N <= 1'b1;
      SCLK <= 1'b1;
      BUSY <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      r_state <= w_state;
      r_div <= w_div;
      r_bit <= w_bit;
      r_pcnt <= !EN ? '0 : (r_pcnt == PMAX ? '0 : r_pcnt + 1'b1);
      r_pend <= w_busy && (w_pend || w_req);
      r_pend_tick <= w_busy && (w_pend ? r_pend_tick : (w_tick && !START));
      CS_N <= !(w_state inside {SETUP, SHIFT, HOLD});
      SCLK <= w_sclk;
      BUSY <= w_state != IDLE;
      FRAME_DONE <= r_state == HOLD && w_state == QUIET;
    end
  end
endmodule

// File: tb/tb_spi_frame_gen.sv
// tb_spi_frame_gen: frame-age reference model plus literal timing checks for spi_frame_gen
module tb_spi_frame_gen;
  localparam int D = 4, F = 16, P = 208;
  localparam int L = (2 * F + 3) * D, CSL = (2 * F + 2) * D;
  logic MCLK = 0, RST_N = 0, EN = 0, START = 0, EN2 = 0;
  logic CS_N, SCLK, BUSY, FRAME_DONE, CS2, SCLK2, BUSY2, DONE2;
  logic [15:0] pat = 16'h0ABC;
  logic [15:0] cap = '0;
  int checks = 0, errors = 0, ncyc = 0, phase = 0, pphase = 0;
  int age = 0, pcnt = 0;
  bit pend = 0, ptick = 0, rst_s = 0;
  always #5 MCLK = ~MCLK;
  spi_frame_gen #(.CLK_DIV(D), .FRAME_BITS(F), .FRAME_PERIOD(P)) dut (
    .MCLK(MCLK), .RST_N(RST_N), .EN(EN), .START(START),
    .CS_N(CS_N), .SCLK(SCLK), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE));
  spi_frame_gen #(.CLK_DIV(2), .FRAME_BITS(16), .FRAME_PERIOD(70)) dut2 (
    .MCLK(MCLK), .RST_N(RST_N), .EN(EN2), .START(1'b0),
    .CS_N(CS2), .SCLK(SCLK2), .BUSY(BUSY2), .FRAME_DONE(DONE2));
  function automatic bit e_cs(int a);
    return !(a >= 1 && a <= CSL);
  endfunction
  function automatic bit e_sclk(int a);
    return (a >= D + 1 && a <= D + 2 * F * D) ? (((a - D - 1) / D) % 2 == 1) : 1'b1;
  endfunction
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at cycle %0d", nm, act, exp, ncyc);
    end
  endtask
  // model: age = cycles since the start condition was sampled, 0 when idle
  initial forever begin
    bit tick, pv;
    @(posedge MCLK);
    tick = EN && pcnt == 0;
    pv = pend && !(ptick && !EN);
    rst_s = RST_N;
    if (!RST_N) begin
      age = 0; pcnt = 0; pend = 0; ptick = 0;
    end else begin
      pcnt = EN ? (pcnt == P - 1 ? 0 : pcnt + 1) : 0;
      if (age == 0) begin
        if (START || tick || pv) age = 1;
        pend = 0; ptick = 0;
      end else begin
        age = (age == L) ? 0 : age + 1;
        ptick = pv ? ptick : (tick && !START);
        pend = pv || START || tick;
      end
    end
  end
  initial forever begin
    int cs_fall, last_rise, nrise, done_at, busy_fall, frames, dones, fall_en, f2_last, nrise2;
    bit got_sfall, p_cs, p_sclk, p_busy, p_cs2, p_sclk2;
    if (ncyc == 0) begin
      cs_fall = -1; last_rise = -1; nrise = 0; done_at = -1; busy_fall = -1; frames = 0; dones = 0;
      fall_en = -1; f2_last = -1; nrise2 = 0; got_sfall = 0;
      p_cs = 1; p_sclk = 1; p_busy = 0; p_cs2 = 1; p_sclk2 = 1;
    end
    @(negedge MCLK);
    ncyc++;
    if (phase != pphase) begin
      if (pphase == 1) begin chk("frames_single", frames, 1); chk("dones_single", dones, 1); end
      if (pphase == 2) chk("frames_freerun", frames, 5);
      if (pphase == 3) chk("frames_pending", frames, 2);
      if (pphase == 4) begin chk("frames_reset", frames, 2); chk("dones_reset", dones, 1); end
      frames = 0; dones = 0; fall_en = -1; pphase = phase;
    end
    chk("cs_n", CS_N, e_cs(age));
    chk("sclk", SCLK, e_sclk(age));
    chk("busy", BUSY, age != 0);
    chk("frame_done", FRAME_DONE, age == CSL + 1);
    if (!rst_s) begin
      if (phase == 4) chk("rst_out", {CS_N, SCLK, BUSY, FRAME_DONE}, 4'b1100);
      cs_fall = -1; last_rise = -1; nrise = 0; done_at = -1; f2_last = -1; nrise2 = 0; fall_en = -1;
    end else begin
      if (p_cs && !CS_N) begin
        cs_fall = ncyc; nrise = 0; cap = '0; last_rise = -1; got_sfall = 0; frames++;
        if (phase == 2 && fall_en >= 0) chk("period", ncyc - fall_en, 208);
        if (phase == 2) fall_en = ncyc;
        if (phase == 3 && frames == 2) chk("pend_gap", ncyc - busy_fall, 1);
      end
      if (!p_cs && CS_N && cs_fall >= 0) chk("cs_low", ncyc - cs_fall, 136);
      if (p_sclk && !SCLK && !got_sfall && cs_fall >= 0) begin
        got_sfall = 1;
        chk("setup", ncyc - cs_fall, 4);
      end
      if (!p_sclk && SCLK && !CS_N) begin
        if (last_rise >= 0) chk("rise_gap", ncyc - last_rise, 8);
        last_rise = ncyc;
        cap = {cap[14:0], nrise < 16 ? pat[15 - nrise] : 1'b0};
        nrise++;
      end
      if (FRAME_DONE) begin
        dones++; done_at = ncyc;
        chk("edges", nrise, 16);
        chk("loopback", cap, 16'h0ABC);
      end
      if (p_busy && !BUSY) begin
        busy_fall = ncyc;
        if (done_at >= 0) chk("quiet", ncyc - done_at, 4);
        done_at = -1;
      end
      if (p_cs2 && !CS2) begin
        if (f2_last >= 0) chk("b2b", ncyc - f2_last, 71);
        f2_last = ncyc; nrise2 = 0;
      end
      if (!p_sclk2 && SCLK2 && !CS2) nrise2++;
      if (DONE2) chk("edges2", nrise2, 16);
    end
    p_cs = CS_N; p_sclk = SCLK; p_busy = BUSY; p_cs2 = CS2; p_sclk2 = SCLK2;
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge MCLK);
      #1;
    end
  endtask
  task automatic pulse;
    START = 1; tick(); START = 0;
  endtask
  initial begin
    tick(3);
    RST_N = 1; EN2 = 1;
    tick(5);
    phase = 1; pulse(); tick(200);
    phase = 2; EN = 1; tick(1000); EN = 0; tick(200);
    phase = 3; pulse(); tick(53); pulse(); tick(9); pulse(); tick(400);
    phase = 4; pulse(); tick(43);
    RST_N = 0; START = 1; EN = 1; tick();
    RST_N = 1; START = 0; EN = 0; tick(20);
    pulse(); tick(200);
    phase = 5;
    for (int i = 0; i < 6000; i++) begin
      START = $urandom_range(0, 39) == 0;
      if ($urandom_range(0, 299) == 0) EN = ~EN;
      RST_N = $urandom_range(0, 1999) != 0;
      tick();
    end
    phase = 6; START = 0; EN = 0; RST_N = 1; tick(300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
